multicycle_control_fsm: RTL

//  Multi-cycle sequencer for the RV64 subset datapath (R-type add/sub/and/or, ld, sd, beq).

---
 rtl/multicycle_control_fsm.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencer for the RV64 subset datapath (add/sub/and/or, ld, sd, beq).
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath
// enables, mux selects and ALU operation. Illegal encodings and memory timeouts park
// the sequencer in HALT until reset.
module multicycle_control_fsm #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [3:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_src,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [3:0]       alu_operation,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count,
    output logic [2:0]       state
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t        cur;
    state_t        nxt;
    logic [6:0]    op_q;
    logic [3:0]    fn_q;
    logic [TW-1:0] timer;
    logic          waiting;
    logic          timeout_hit;
    logic          is_r;
    logic          is_ld;
    logic          is_sd;
    logic          is_beq;
    logic          decode_ok;

    function automatic logic funct_ok(input logic [3:0] f);
        case (f)
            4'b0000, 4'b1000, 4'b0111, 4'b0110: funct_ok = 1'b1;
            default:                            funct_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] r_alu_op(input logic [3:0] f);
        case (f)
            4'b1000: r_alu_op = ALU_SUB;
            4'b0111: r_alu_op = ALU_AND;
            4'b0110: r_alu_op = ALU_OR;
            default: r_alu_op = ALU_ADD;
        endcase
    endfunction

    assign is_r    = (op_q == OP_R);
    assign is_ld   = (op_q == OP_LD);
    assign is_sd   = (op_q == OP_SD);
    assign is_beq  = (op_q == OP_BEQ);

    assign decode_ok = (opcode == OP_LD) || (opcode == OP_SD) || (opcode == OP_BEQ) ||
                       ((opcode == OP_R) && funct_ok(funct));

    assign waiting     = ((cur == S_FETCH) || (cur == S_MEM)) && !mem_ready;
    assign timeout_hit = waiting && (timer == TW'(TIMEOUT - 1));

    assign state   = cur;
    assign illegal = (cur == S_HALT);

    // State register, latched instruction fields, wait timer and retire counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur         <= S_IDLE;
            op_q        <= '0;
            fn_q        <= '0;
            timer       <= '0;
            instr_count <= '0;
        end else begin
            cur <= nxt;
            if (cur == S_DECODE) begin
                op_q <= opcode;
                fn_q <= funct;
            end
            timer <= waiting ? timer + TW'(1) : '0;
            if (instr_done) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    // Next-state selection
    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE: begin
                if (run) nxt = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready)        nxt = S_DECODE;
                else if (timeout_hit) nxt = S_HALT;
            end
            S_DECODE: begin
                nxt = decode_ok ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                if (is_r)                nxt = S_WB;
                else if (is_ld || is_sd) nxt = S_MEM;
                else                     nxt = run ? S_FETCH : S_IDLE;
            end
            S_MEM: begin
                if (mem_ready)        nxt = is_ld ? S_WB : (run ? S_FETCH : S_IDLE);
                else if (timeout_hit) nxt = S_HALT;
            end
            S_WB: begin
                nxt = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                nxt = S_HALT;
            end
            default: begin
                nxt = S_IDLE;
            end
        endcase
    end

    // Datapath control outputs from state and latched instruction
    always_comb begin
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        alu_src       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_operation = ALU_ADD;
        instr_done    = 1'b0;
        case (cur)
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_EXEC: begin
                if (is_r) begin
                    alu_operation = r_alu_op(fn_q);
                end else if (is_beq) begin
                    alu_operation = ALU_SUB;
                    pc_write      = zero;
                    pc_src        = zero;
                    instr_done    = 1'b1;
                end else begin
                    alu_src = 1'b1;
                end
            end
            S_MEM: begin
                mem_read   = is_ld;
                mem_write  = is_sd;
                instr_done = is_sd && mem_ready;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_ld;
                instr_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
